// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Each bit is sampled at mid-bit; rx_valid / frame_err / parity_err are one-clk pulses.
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s low
// START  | qualifying start bit, sampled at half-bit
// DATA   | shifting in 8 data bits, LSB first
// PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit, issuing the frame result strobe
// BREAK  | stop bit was low; waiting for the line to return high

module uart_rx #(
    parameter int CLK_FREQ  = 1000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);
    localparam int DIV   = CLK_FREQ / (BAUD_RATE * 16);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    if (DIV < 1) begin : g_bad_div
        $error("uart_rx: CLK_FREQ/(BAUD_RATE*16) must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_e;

`ifdef UART_RX_PARITY_EN
    localparam state_e AFTER_DATA = PARITY;
`else
    localparam state_e AFTER_DATA = STOP;
`endif

    state_e           state_q, state_d;
    logic             sync1_q, sync2_q;
    logic             rx_s;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]       os_cnt_q, os_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             tick, mid_tick, bit_tick;
`ifdef UART_RX_PARITY_EN
    logic             parity_bad_q, parity_bad_d;
    logic             parity_err_q, parity_err_d;
`endif

    assign rx_s     = sync2_q;
    assign tick     = (div_cnt_q == DIV_LAST);
    assign mid_tick = tick && (os_cnt_q == 4'd7);
    assign bit_tick = tick && (os_cnt_q == 4'd15);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!rx_s) state_d = START;
            START:   if (mid_tick) state_d = rx_s ? IDLE : DATA;
            DATA:    if (bit_tick && (bit_cnt_q == 3'd7)) state_d = AFTER_DATA;
            PARITY:  if (bit_tick) state_d = STOP;
            STOP:    if (bit_tick) state_d = rx_s ? IDLE : BREAK;
            BREAK:   if (rx_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counters sit at zero outside a frame, so every frame starts its mid-bit
    // alignment from the moment the start edge is seen.
    always_comb begin
        div_cnt_d = div_cnt_q;
        os_cnt_d  = os_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
`ifdef UART_RX_PARITY_EN
        parity_bad_d = parity_bad_q;
`endif
        if (state_q == IDLE || state_q == BREAK) begin
            div_cnt_d = '0;
            os_cnt_d  = '0;
        end else begin
            div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
            if (tick) begin
                os_cnt_d = os_cnt_q + 4'd1;
            end
            if (state_q == START && mid_tick) begin
                os_cnt_d  = '0;
                bit_cnt_d = '0;
            end
            if (state_q == DATA && bit_tick) begin
                shreg_d   = {rx_s, shreg_q[7:1]};
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
`ifdef UART_RX_PARITY_EN
            if (state_q == PARITY && bit_tick) begin
                parity_bad_d = ^{shreg_q, rx_s};
            end
`endif
        end
    end

    always_comb begin
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_d = 1'b0;
`endif
        if (state_q == STOP && bit_tick) begin
            if (!rx_s) begin
                frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (parity_bad_q) begin
                parity_err_d = 1'b1;
`endif
            end else begin
                rx_valid_d = 1'b1;
                rx_data_d  = shreg_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            div_cnt_q   <= '0;
            os_cnt_q    <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync1_q     <= rx;
            sync2_q     <= sync1_q;
            div_cnt_q   <= div_cnt_d;
            os_cnt_q    <= os_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= parity_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx; frames are described at the bit level and the
// expected strobe sequence comes from a frame-level model of the receiver.

module tb_uart_rx;
    localparam int CLK_FREQ  = 1600000;
    localparam int BAUD_RATE = 10000;
    localparam int DIV       = CLK_FREQ / (BAUD_RATE * 16);
    localparam int BIT       = DIV * 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    // bits after the start bit, stop included
    localparam int FRAME_BITS = PAR_EN ? 10 : 9;
    localparam int K_VALID = 1;
    localparam int K_FERR  = 2;
    localparam int K_PERR  = 3;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    longint     cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         both_cnt = 0;
    logic [7:0] exp_last = 8'h00;

    int         ev_kind[$];
    logic [7:0] ev_data[$];
    longint     ev_cyc[$];
    int         exp_kind[$];
    logic [7:0] exp_data[$];
    longint     exp_cyc[$];

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            ev_kind.push_back(K_VALID);
            ev_data.push_back(rx_data);
            ev_cyc.push_back(cyc);
        end
        if (frame_err) begin
            ev_kind.push_back(K_FERR);
            ev_data.push_back(8'h00);
            ev_cyc.push_back(cyc);
        end
        if (parity_err) begin
            ev_kind.push_back(K_PERR);
            ev_data.push_back(8'h00);
            ev_cyc.push_back(cyc);
        end
        if (rx_valid && frame_err) both_cnt <= both_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Frame outcome: a low stop bit wins; otherwise a bad even parity (8E1 only); else a good byte.
    function automatic int model_kind(input logic [7:0] d, input logic stop_b, input logic par_bit);
        if (!stop_b) return K_FERR;
        if (PAR_EN && (((^d) ^ par_bit) != 1'b0)) return K_PERR;
        return K_VALID;
    endfunction

    function automatic void clear_events();
        ev_kind.delete();
        ev_data.delete();
        ev_cyc.delete();
        exp_kind.delete();
        exp_data.delete();
        exp_cyc.delete();
    endfunction

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Must be called just after a negedge; leaves rx at the stop-bit level.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
        logic par_bit;
        int   kind;
        par_bit = (^d) ^ par_flip;
        kind    = model_kind(d, stop_b, par_bit);
        exp_kind.push_back(kind);
        exp_data.push_back(d);
        exp_cyc.push_back(cyc + 2 + BIT / 2 + FRAME_BITS * BIT + 1);
        if (kind == K_VALID) exp_last = d;
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT) @(negedge clk);
        end
        if (PAR_EN) begin
            rx = par_bit;
            repeat (BIT) @(negedge clk);
        end
        rx = stop_b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        rst = 1'b0;
        clear_events();
        exp_last = 8'h00;
        idle(2000);
        n_checks++;
        if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h, expected 00", rx_data); end
        n_checks++;
        if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b, expected 0", rx_valid); end
        n_checks++;
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b, expected 0", frame_err); end
        n_checks++;
        if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err: got %b, expected 0", parity_err); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b, expected 0", busy); end
        n_checks++;
        if (ev_kind.size() != 0) begin n_fail++; $display("FAIL reset_no_strobes: got %0d strobes, expected 0", ev_kind.size()); end
    endtask

    task automatic test_single_byte();
        longint lat;
        clear_events();
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(200);
        n_checks++;
        if (ev_kind.size() != 1) begin
            n_fail++; $display("FAIL single_count: got %0d strobes, expected 1", ev_kind.size());
        end else begin
            n_checks++;
            if (ev_kind[0] !== K_VALID) begin n_fail++; $display("FAIL single_kind: got %0d, expected %0d", ev_kind[0], K_VALID); end
            n_checks++;
            if (ev_data[0] !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h, expected a5", ev_data[0]); end
            lat = ev_cyc[0] - exp_cyc[0];
            n_checks++;
            if (lat >= DIV || lat <= -DIV) begin n_fail++; $display("FAIL single_latency: got cycle %0d, expected %0d", ev_cyc[0], exp_cyc[0]); end
        end
        n_checks++;
        if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL single_hold: got %h, expected a5", rx_data); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [2];
        longint lat;
        vals[0] = 8'h3C;
        vals[1] = 8'hC3;
        clear_events();
        send_frame(vals[0], 1'b1, 1'b0);
        send_frame(vals[1], 1'b1, 1'b0);
        idle(200);
        n_checks++;
        if (ev_kind.size() != 2) begin
            n_fail++; $display("FAIL b2b_count: got %0d strobes, expected 2", ev_kind.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (ev_kind[i] !== K_VALID) begin n_fail++; $display("FAIL b2b_kind[%0d]: got %0d, expected %0d", i, ev_kind[i], K_VALID); end
                n_checks++;
                if (ev_data[i] !== vals[i]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h, expected %h", i, ev_data[i], vals[i]); end
                lat = ev_cyc[i] - exp_cyc[i];
                n_checks++;
                if (lat >= DIV || lat <= -DIV) begin n_fail++; $display("FAIL b2b_latency[%0d]: got cycle %0d, expected %0d", i, ev_cyc[i], exp_cyc[i]); end
            end
        end
        n_checks++;
        if (rx_data !== 8'hC3) begin n_fail++; $display("FAIL b2b_hold: got %h, expected c3", rx_data); end
    endtask

    task automatic test_glitch();
        logic seen;
        seen = 1'b0;
        clear_events();
        rx = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        rx = 1'b1;
        repeat (300) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_seen: got %b, expected 1", seen); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_end: got %b, expected 0", busy); end
        n_checks++;
        if (ev_kind.size() != 0) begin n_fail++; $display("FAIL glitch_no_strobes: got %0d strobes, expected 0", ev_kind.size()); end
    endtask

    task automatic test_break();
        logic [7:0] prev;
        longint     lat;
        prev = exp_last;
        clear_events();
        send_frame(8'h55, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (3000) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL break_busy: got %b, expected 1", busy); end
        idle(300);
        n_checks++;
        if (ev_kind.size() != 1) begin
            n_fail++; $display("FAIL break_count: got %0d strobes, expected 1", ev_kind.size());
        end else begin
            n_checks++;
            if (ev_kind[0] !== K_FERR) begin n_fail++; $display("FAIL break_kind: got %0d, expected %0d", ev_kind[0], K_FERR); end
            lat = ev_cyc[0] - exp_cyc[0];
            n_checks++;
            if (lat >= DIV || lat <= -DIV) begin n_fail++; $display("FAIL break_latency: got cycle %0d, expected %0d", ev_cyc[0], exp_cyc[0]); end
        end
        n_checks++;
        if (rx_data !== prev) begin n_fail++; $display("FAIL break_hold: got %h, expected %h", rx_data, prev); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL break_exit: got %b, expected 0", busy); end
        clear_events();
        send_frame(8'h0F, 1'b1, 1'b0);
        idle(200);
        n_checks++;
        if (ev_kind.size() != 1 || ev_kind[0] !== K_VALID || ev_data[0] !== 8'h0F) begin
            n_fail++; $display("FAIL break_recover: got %0d strobes, data %h, expected one byte 0f", ev_kind.size(), rx_data);
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_events();
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy_before: got %b, expected 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_last = 8'h00;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy_after: got %b, expected 0", busy); end
        n_checks++;
        if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rst_mid_rx_data: got %h, expected 00", rx_data); end
        idle(7 * BIT);
        n_checks++;
        if (ev_kind.size() != 0) begin n_fail++; $display("FAIL rst_mid_no_strobes: got %0d strobes, expected 0", ev_kind.size()); end
        clear_events();
        send_frame(8'h81, 1'b1, 1'b0);
        idle(200);
        n_checks++;
        if (ev_kind.size() != 1 || ev_kind[0] !== K_VALID || ev_data[0] !== 8'h81) begin
            n_fail++; $display("FAIL rst_mid_recover: got %0d strobes, data %h, expected one byte 81", ev_kind.size(), rx_data);
        end
`ifdef UART_RX_PARITY_EN
        clear_events();
        send_frame(8'h81, 1'b1, 1'b1);
        idle(200);
        n_checks++;
        if (ev_kind.size() != 1 || ev_kind[0] !== K_PERR) begin
            n_fail++; $display("FAIL parity_err_pulse: got %0d strobes, expected one parity_err", ev_kind.size());
        end
        n_checks++;
        if (rx_data !== 8'h81) begin n_fail++; $display("FAIL parity_hold: got %h, expected 81", rx_data); end
`endif
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       stop_b;
        logic       flip;
        int         gap;
        longint     lat;
        clear_events();
        for (int f = 0; f < 12; f++) begin
            d      = 8'($urandom_range(0, 255));
            stop_b = ($urandom_range(0, 3) != 0);
            flip   = ($urandom_range(0, 3) == 0);
            send_frame(d, stop_b, flip);
            gap = stop_b ? int'($urandom_range(0, 300)) : int'($urandom_range(20, 300));
            if (gap > 0) idle(gap);
        end
        idle(400);
        n_checks++;
        if (ev_kind.size() != exp_kind.size()) begin
            n_fail++; $display("FAIL rand_count: got %0d strobes, expected %0d", ev_kind.size(), exp_kind.size());
        end
        for (int i = 0; i < exp_kind.size() && i < ev_kind.size(); i++) begin
            n_checks++;
            if (ev_kind[i] !== exp_kind[i]) begin n_fail++; $display("FAIL rand_kind[%0d]: got %0d, expected %0d", i, ev_kind[i], exp_kind[i]); end
            if (exp_kind[i] == K_VALID) begin
                n_checks++;
                if (ev_data[i] !== exp_data[i]) begin n_fail++; $display("FAIL rand_data[%0d]: got %h, expected %h", i, ev_data[i], exp_data[i]); end
            end
            lat = ev_cyc[i] - exp_cyc[i];
            n_checks++;
            if (lat >= DIV || lat <= -DIV) begin n_fail++; $display("FAIL rand_latency[%0d]: got cycle %0d, expected %0d", i, ev_cyc[i], exp_cyc[i]); end
        end
        n_checks++;
        if (rx_data !== exp_last) begin n_fail++; $display("FAIL rand_hold: got %h, expected %h", rx_data, exp_last); end
        n_checks++;
        if (both_cnt != 0) begin n_fail++; $display("FAIL valid_and_ferr_together: got %0d cycles, expected 0", both_cnt); end
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_glitch();
        test_break();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
